// File: rtl/edge_bank_accumulator.sv
// ---------------------------------------------------------------------------
// edge_bank_accumulator
//
// Accepts LANES edge streams (dst address + value) with per-lane valid/ready
// handshakes. Each edge is routed to one of NUM banks by address interleave
// (bank = dst mod NUM, row = dst / NUM). Its value is then accumulated into a
// double-buffered result store, in either sum mode (wrapping) or unsigned-max
// mode. The inactive buffer can be read one NUM-wide row at a time while the
// active buffer keeps accumulating. A swap flips the buffers and zeroes the
// newly active one, one row per cycle.
//
// Ports:
//   clk       single rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  per-lane edge valid
//   in_ready  per-lane accept (combinational on lower lanes' valid/dst)
//   in_dst    lane l destination at [l*ADDRW +: ADDRW]
//   in_value  lane l value at [l*WL +: WL]
//   op_mode   0 = sum mod 2^WL, 1 = unsigned max (sampled at accept)
//   swap_req  single-cycle pulse: flip buffers (ignored while clearing)
//   busy      clear of the active buffer in progress
//   rd_en     read request against the inactive buffer
//   rd_addr   row to read
//   rd_data   bank b word at [b*WL +: WL], valid one cycle after rd_en
//   rd_valid  rd_data valid strobe
//   drop_cnt  out-of-range edges accepted since the last swap (saturating)
// ---------------------------------------------------------------------------
module edge_bank_accumulator #(
  parameter int ADDRW = 16,
  parameter int WL    = 32,
  parameter int NUM   = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 64,
  localparam int RW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES-1:0]       in_ready,
  input  logic [LANES*ADDRW-1:0] in_dst,
  input  logic [LANES*WL-1:0]    in_value,
  input  logic                   op_mode,
  input  logic                   swap_req,
  output logic                   busy,
  input  logic                   rd_en,
  input  logic [RW-1:0]          rd_addr,
  output logic [WL*NUM-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [15:0]            drop_cnt
);

  localparam int BW   = $clog2(NUM);
  localparam int CAPW = BW + RW;              // bits addressing NUM*DEPTH entries
  localparam int XW   = ADDRW + CAPW;         // dst padded so slicing is always legal
  localparam int CW   = $clog2(LANES + 1);    // per-cycle drop count width

  typedef enum logic {
    ACCUM = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic          bufsel;     // buffer currently accumulating
  logic [RW-1:0] clr_cnt;

  // -------------------------------------------------------------------------
  // Lane address decode
  // -------------------------------------------------------------------------
  logic [BW-1:0]    lane_bank [LANES];
  logic [RW-1:0]    lane_row  [LANES];
  logic [WL-1:0]    lane_val  [LANES];
  logic [LANES-1:0] lane_inrange;
  logic [LANES-1:0] accept;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [XW-1:0] dst_ext;
    assign dst_ext          = XW'(in_dst[gi*ADDRW +: ADDRW]);
    assign lane_bank[gi]    = dst_ext[BW-1:0];
    assign lane_row[gi]     = dst_ext[BW +: RW];
    assign lane_val[gi]     = in_value[gi*WL +: WL];
    // Anything at or above NUM*DEPTH has a nonzero bit above the capacity field.
    assign lane_inrange[gi] = ((dst_ext >> CAPW) == '0);
  end

  // -------------------------------------------------------------------------
  // Ready: a lane yields to any lower lane holding a valid in-range edge for
  // the same bank, so each bank sees at most one write per cycle. Out-of-range
  // lanes never touch the store and are never held back.
  // -------------------------------------------------------------------------
  logic blocked;

  always_comb begin
    in_ready = '0;
    blocked  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      blocked = 1'b0;
      for (int k = 0; k < l; k++) begin
        if (in_valid[k] && lane_inrange[k] && (lane_bank[k] == lane_bank[l])) begin
          blocked = 1'b1;
        end
      end
      in_ready[l] = (state == ACCUM) && (!lane_inrange[l] || !blocked);
    end
  end

  assign accept = in_valid & in_ready;

  // -------------------------------------------------------------------------
  // Per-bank write steering (conflict-free by construction of in_ready)
  // -------------------------------------------------------------------------
  logic [NUM-1:0] acc_en;
  logic [RW-1:0]  acc_row [NUM];
  logic [WL-1:0]  acc_val [NUM];

  always_comb begin
    acc_en = '0;
    for (int b = 0; b < NUM; b++) begin
      acc_row[b] = '0;
      acc_val[b] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (accept[l] && lane_inrange[l]) begin
        acc_en[lane_bank[l]]  = 1'b1;
        acc_row[lane_bank[l]] = lane_row[l];
        acc_val[lane_bank[l]] = lane_val[l];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Out-of-range drop accounting
  // -------------------------------------------------------------------------
  logic [CW-1:0] drop_inc;
  logic [16:0]   drop_sum;

  always_comb begin
    drop_inc = '0;
    for (int l = 0; l < LANES; l++) begin
      if (accept[l] && !lane_inrange[l]) begin
        drop_inc = drop_inc + CW'(1);
      end
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
  end

  // -------------------------------------------------------------------------
  // Control FSM: CLEAR walks every row of the active buffer once, then hands
  // over to ACCUM. Reset enters CLEAR so buffer 0 starts zeroed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      bufsel   <= 1'b0;
      clr_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (swap_req) begin
            // Edges accepted this cycle still land in the old active buffer,
            // because the store write below uses the pre-toggle bufsel.
            bufsel   <= ~bufsel;
            state    <= CLEAR;
            clr_cnt  <= '0;
            drop_cnt <= '0;
          end else if (drop_sum[16]) begin
            drop_cnt <= 16'hFFFF;
          end else begin
            drop_cnt <= drop_sum[15:0];
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + RW'(1);
          if (clr_cnt == RW'(DEPTH - 1)) begin
            state <= ACCUM;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign busy = (state == CLEAR);

  // -------------------------------------------------------------------------
  // Result store: one array per bank holding both buffers, indexed
  // {buffer, row}. The accumulate path reads asynchronously so a row written
  // on one edge is seen by an accept to the same row on the next edge; no
  // forwarding is needed. The read-out port always targets the other buffer.
  // -------------------------------------------------------------------------
  logic [WL*NUM-1:0] rd_word;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_bank
    logic [WL-1:0] mem [2*DEPTH];
    logic [WL-1:0] old_val;
    logic [WL-1:0] new_val;

    assign old_val = mem[{bufsel, acc_row[gi]}];
    assign new_val = op_mode ? ((acc_val[gi] > old_val) ? acc_val[gi] : old_val)
                             : (old_val + acc_val[gi]);

    always_ff @(posedge clk) begin
      if (state == CLEAR) begin
        mem[{bufsel, clr_cnt}] <= '0;
      end else if (acc_en[gi]) begin
        mem[{bufsel, acc_row[gi]}] <= new_val;
      end
    end

    assign rd_word[gi*WL +: WL] = mem[{~bufsel, rd_addr}];
  end

  // Registered read-out; rd_data holds its last value between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_edge_bank_accumulator.sv
// ---------------------------------------------------------------------------
// Self-checking bench for edge_bank_accumulator. A behavioural model holds
// both result buffers as flat arrays indexed directly by dst, and it derives
// readiness, busy, drop count and read data from the address-map and
// handshake rules. Directed scenarios run first, then randomized traffic,
// then a reset issued while a read is in flight.
// ---------------------------------------------------------------------------
module tb_edge_bank_accumulator;

  localparam int ADDRW = 16;
  localparam int WL    = 32;
  localparam int NUM   = 16;
  localparam int LANES = 4;
  localparam int DEPTH = 64;
  localparam int RW    = $clog2(DEPTH);
  localparam int CAP   = NUM * DEPTH;
  localparam int VW    = WL * NUM;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [LANES-1:0]       in_valid;
  logic [LANES-1:0]       in_ready;
  logic [LANES*ADDRW-1:0] in_dst;
  logic [LANES*WL-1:0]    in_value;
  logic                   op_mode;
  logic                   swap_req;
  logic                   busy;
  logic                   rd_en;
  logic [RW-1:0]          rd_addr;
  logic [VW-1:0]          rd_data;
  logic                   rd_valid;
  logic [15:0]            drop_cnt;

  always #5 clk = ~clk;

  edge_bank_accumulator #(
    .ADDRW(ADDRW), .WL(WL), .NUM(NUM), .LANES(LANES), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst), .in_value(in_value),
    .op_mode(op_mode), .swap_req(swap_req), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus state
  bit              l_vld [LANES];
  int unsigned     l_dst [LANES];
  logic [WL-1:0]   l_val [LANES];
  bit              op  = 1'b0;
  bit              swp = 1'b0;
  bit              ren = 1'b0;
  int unsigned     raddr = 0;

  // Reference model
  logic [WL-1:0]    mbuf [2][CAP];
  int               m_bufsel;
  int               m_clear_left;
  int               m_drop;
  bit               m_rd_pend;
  logic [VW-1:0]    m_rd_last;
  logic [LANES-1:0] exp_ready;
  logic [LANES-1:0] acc_mask;
  logic [LANES-1:0] last_ready;
  bit               last_busy;

  task automatic drive();
    for (int l = 0; l < LANES; l++) begin
      in_valid[l]                = l_vld[l];
      in_dst[l*ADDRW +: ADDRW]   = ADDRW'(l_dst[l]);
      in_value[l*WL +: WL]       = l_val[l];
    end
    op_mode  = op;
    swap_req = swp;
    rd_en    = ren;
    rd_addr  = RW'(raddr);
  endtask

  // A lane is ready when accumulating and no lower lane has already claimed
  // its bank with a valid in-range edge; out-of-range lanes claim nothing.
  task automatic calc_ready();
    bit claimed [NUM];
    for (int b = 0; b < NUM; b++) claimed[b] = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      bit inr;
      int b;
      inr = (l_dst[l] < CAP);
      b   = int'(l_dst[l] % NUM);
      exp_ready[l] = (m_clear_left == 0) && (!inr || !claimed[b]);
      if (l_vld[l] && inr) claimed[b] = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [WL-1:0] old;
    if (ren) begin
      m_rd_pend = 1'b1;
      for (int b = 0; b < NUM; b++)
        m_rd_last[b*WL +: WL] = mbuf[1-m_bufsel][int'(raddr)*NUM + b];
    end else begin
      m_rd_pend = 1'b0;
    end
    acc_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l_vld[l] && exp_ready[l]) begin
        acc_mask[l] = 1'b1;
        if (l_dst[l] < CAP) begin
          old = mbuf[m_bufsel][l_dst[l]];
          mbuf[m_bufsel][l_dst[l]] = op ? ((l_val[l] > old) ? l_val[l] : old) : old + l_val[l];
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (swp) begin
      m_bufsel     = 1 - m_bufsel;
      m_clear_left = DEPTH;
      m_drop       = 0;
      for (int i = 0; i < CAP; i++) mbuf[m_bufsel][i] = '0;
    end
  endtask

  // One clock: compare at the falling edge, advance model at the rising edge.
  task automatic step();
    drive();
    calc_ready();
    @(negedge clk);
    last_ready = in_ready;
    last_busy  = busy;
    check("in_ready", VW'(in_ready), VW'(exp_ready));
    check("busy",     VW'(busy),     VW'(m_clear_left > 0));
    check("drop_cnt", VW'(drop_cnt), VW'(m_drop));
    check("rd_valid", VW'(rd_valid), VW'(m_rd_pend));
    check("rd_data",  rd_data,       m_rd_last);
    @(posedge clk);
    model_edge();
    #1;
    for (int l = 0; l < LANES; l++) if (acc_mask[l]) l_vld[l] = 1'b0;
  endtask

  task automatic set_lane(input int l, input int unsigned dst, input logic [WL-1:0] val);
    l_vld[l] = 1'b1;
    l_dst[l] = dst;
    l_val[l] = val;
  endtask

  task automatic drain(output int n);
    logic [LANES-1:0] pend;
    n = 0;
    pend = '0;
    for (int l = 0; l < LANES; l++) pend[l] = l_vld[l];
    while (pend != '0 && n < 20) begin
      step();
      n++;
      for (int l = 0; l < LANES; l++) pend[l] = l_vld[l];
    end
    check("drain_pending", VW'(pend), VW'(0));
  endtask

  task automatic do_swap(input int second_at);
    int n;
    n = 0;
    swp = 1'b1;
    step();
    swp = 1'b0;
    $display("swap issued, readable buffer now %0d", 1 - m_bufsel);
    for (int i = 0; i < DEPTH + 3; i++) begin
      swp = (i == second_at);
      step();
      swp = 1'b0;
      if (last_busy) n++;
    end
    check("swap_busy_cycles", VW'(n), VW'(DEPTH));
  endtask

  task automatic read_row(input int r);
    ren   = 1'b1;
    raddr = r;
    step();
    ren = 1'b0;
    $display("read row %0d data=%0h", r, rd_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    swp = 1'b0;
    ren = 1'b0;
    for (int l = 0; l < LANES; l++) l_vld[l] = 1'b0;
    drive();
    #1;
    check("rst_rd_valid", VW'(rd_valid), VW'(0));
    check("rst_rd_data",  rd_data,       VW'(0));
    check("rst_busy",     VW'(busy),     VW'(1));
    check("rst_drop",     VW'(drop_cnt), VW'(0));
    check("rst_ready",    VW'(in_ready), VW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_bufsel     = 0;
    m_clear_left = DEPTH;
    m_drop       = 0;
    m_rd_pend    = 1'b0;
    m_rd_last    = '0;
    for (int i = 0; i < CAP; i++) mbuf[0][i] = '0;
    repeat (DEPTH) step();
    check("busy_after_depth", VW'(busy),     VW'(0));
    check("ready_idle",       VW'(in_ready), VW'({LANES{1'b1}}));
    check("drop_after_reset", VW'(drop_cnt), VW'(0));
    $display("reset complete");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic [WL-1:0] cvals [4];
    logic [WL-1:0] mseq  [4];
    for (int l = 0; l < LANES; l++) begin
      l_vld[l] = 1'b0; l_dst[l] = 0; l_val[l] = '0;
    end
    drive();
    #2;
    do_reset();

    // Sum mode: three back-to-back hits on the same bank/row.
    op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 5, 32'd10);
      step();
    end
    do_swap(-1);
    read_row(0);
    check("sum_row0", rd_data, VW'(32'd30) << (5*WL));

    // Bank conflict: four lanes aimed at bank 3, rows 0..3.
    cvals[0] = 32'd100; cvals[1] = 32'd200; cvals[2] = 32'd300; cvals[3] = 32'd400;
    for (int l = 0; l < 4; l++) set_lane(l, 3 + 16*l, cvals[l]);
    step();
    check("conflict_ready_first", VW'(last_ready), VW'(4'b0001));
    drain(n);
    check("conflict_cycles", VW'(n + 1), VW'(4));
    do_swap(-1);
    for (int r = 0; r < 4; r++) begin
      read_row(r);
      check("conflict_bank3", VW'(rd_data[3*WL +: WL]), VW'(cvals[r]));
    end

    // Max mode, then the same sequence in sum mode (wraps).
    mseq[0] = 32'd9; mseq[1] = 32'd4; mseq[2] = 32'hFFFF_FFF0; mseq[3] = 32'd12;
    op = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 7, mseq[i]);
      step();
    end
    do_swap(-1);
    read_row(0);
    check("max_bank7", VW'(rd_data[7*WL +: WL]), VW'(32'hFFFF_FFF0));
    op = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 7, mseq[i]);
      step();
    end
    do_swap(-1);
    read_row(0);
    check("sum_wrap_bank7", VW'(rd_data[7*WL +: WL]), VW'(32'h9));

    // Out-of-range edges, then a swap with an ignored second pulse in CLEAR.
    for (int i = 0; i < 3; i++) begin
      set_lane(0, CAP, $urandom);
      set_lane(1, CAP, $urandom);
      step();
    end
    check("drop_cnt_six", VW'(drop_cnt), VW'(6));
    do_swap(5);
    check("drop_cleared", VW'(drop_cnt), VW'(0));
    read_row(0);
    check("oor_no_write", rd_data, VW'(0));

    // Randomized traffic with occasional swaps and reads.
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < LANES; l++) begin
        if (!l_vld[l] && ($urandom % 3 == 0)) begin
          int unsigned sel;
          int unsigned d;
          sel = $urandom % 10;
          if (sel == 0)      d = CAP + ($urandom % (65536 - CAP));
          else if (sel < 5)  d = ($urandom % 8) * NUM + ($urandom % 3);
          else               d = $urandom % CAP;
          set_lane(l, d, ($urandom % 2 == 1) ? 32'($urandom) : 32'($urandom % 100));
        end
      end
      op    = ($urandom % 4 == 0);
      ren   = ($urandom % 3 == 0);
      raddr = $urandom % DEPTH;
      swp   = ($urandom % 50 == 0);
      step();
    end
    swp = 1'b0;

    // Reset while a read is in flight drops its rd_valid.
    ren   = 1'b1;
    raddr = 3;
    step();
    ren = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
